// File: rtl/mcpu_pkg.sv
// mcpu shared types: datapath widths, special register indices
// and the decode-stage scoreboard slot.
package mcpu_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 4;

    // General registers R0..R7 sit below the special registers.
    localparam logic [REG_AW-1:0] SP_ADDR = 4'd8;
    localparam logic [REG_AW-1:0] T_ADDR  = 4'd9;
    localparam logic [REG_AW-1:0] IH_ADDR = 4'd10;

    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] addr;
        logic              load;
    } sb_slot_t;

    localparam sb_slot_t SLOT_BUBBLE = '0;

    function automatic logic slot_hit(
        input sb_slot_t          s,
        input logic              en,
        input logic [REG_AW-1:0] a
    );
        return en & s.we & (s.addr == a);
    endfunction

endpackage

// File: rtl/id_fwd_scoreboard_if.sv
// Decode-stage operand/hazard bundle between ID control, the
// register file, downstream stages and the forwarding scoreboard.
interface id_fwd_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int NUM_RD = 2,
    parameter int DEPTH  = 3,
    parameter int CNT_W  = 4
);

    logic                     id_valid_i;
    logic [NUM_RD-1:0]        rd_en_i;
    logic [NUM_RD*REG_AW-1:0] rd_addr_i;
    logic [NUM_RD*DATA_W-1:0] rf_data_i;
    logic                     wr_en_i;
    logic [REG_AW-1:0]        wr_addr_i;
    logic                     is_load_i;
    logic [DEPTH*DATA_W-1:0]  stage_wdata_i;
    logic                     flush_i;
    logic                     hold_i;
    logic [NUM_RD*DATA_W-1:0] opnd_o;
    logic                     stall_o;
    logic                     issue_o;
    logic [CNT_W-1:0]         stall_cnt_o;
    logic                     timeout_o;

    modport master (
        output id_valid_i, rd_en_i, rd_addr_i, rf_data_i,
        output wr_en_i, wr_addr_i, is_load_i,
        output stage_wdata_i, flush_i, hold_i,
        input  opnd_o, stall_o, issue_o,
        input  stall_cnt_o, timeout_o
    );

    modport slave (
        input  id_valid_i, rd_en_i, rd_addr_i, rf_data_i,
        input  wr_en_i, wr_addr_i, is_load_i,
        input  stage_wdata_i, flush_i, hold_i,
        output opnd_o, stall_o, issue_o,
        output stall_cnt_o, timeout_o
    );

endinterface

// File: rtl/id_fwd_scoreboard_fwd_mux.sv
// Per-read-port priority selector: youngest matching slot
// supplies the operand and flags a too-young load.
module fwd_mux
    import mcpu_pkg::*;
#(
    parameter int DW         = 16,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2
) (
    input  sb_slot_t [DEPTH-1:0] slots,
    input  logic [DEPTH*DW-1:0]  stage_data,
    input  logic [DW-1:0]        rf_data,
    input  logic                 rd_en,
    input  logic [REG_AW-1:0]    rd_addr,
    output logic [DW-1:0]        opnd,
    output logic                 hazard
);

    logic hit;

    always_comb begin
        opnd   = rf_data;
        hazard = 1'b0;
        hit    = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!hit && slot_hit(slots[k], rd_en, rd_addr)) begin
                hit    = 1'b1;
                opnd   = stage_data[k*DW +: DW];
                hazard = slots[k].load && (k < LOAD_STAGE);
            end
        end
    end

endmodule

// File: rtl/id_fwd_scoreboard.sv
// Decode operand resolution: tracks in-flight writes, forwards
// from EX/MEM/WB, interlocks load-use and watches stall length.
module id_fwd_scoreboard
    import mcpu_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_AW     = 4,
    parameter int NUM_RD     = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int MAX_STALL  = 15
) (
    input  logic     clk,
    input  logic     rst,
    id_fwd_if.slave  bus
);

    localparam int CNT_W = $clog2(MAX_STALL + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STALL);

    sb_slot_t [DEPTH-1:0]     sb_q;
    sb_slot_t                 push;
    logic [NUM_RD-1:0]        hz;
    logic [NUM_RD*DATA_W-1:0] mux_opnd;
    logic                     stall;
    logic                     issue;
    logic [CNT_W-1:0]         cnt_q;
    logic [CNT_W-1:0]         cnt_d;
    logic                     to_q;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        fwd_mux #(
            .DW         (DATA_W),
            .DEPTH      (DEPTH),
            .LOAD_STAGE (LOAD_STAGE)
        ) u_mux (
            .slots      (sb_q),
            .stage_data (bus.stage_wdata_i),
            .rf_data    (bus.rf_data_i[p*DATA_W +: DATA_W]),
            .rd_en      (bus.rd_en_i[p]),
            .rd_addr    (bus.rd_addr_i[p*REG_AW +: REG_AW]),
            .opnd       (mux_opnd[p*DATA_W +: DATA_W]),
            .hazard     (hz[p])
        );
    end

    // Flush beats a hazard: the instruction is discarded anyway.
    always_comb begin
        stall = ~rst & bus.id_valid_i & ~bus.flush_i & (|hz);
        issue = ~rst & bus.id_valid_i & ~stall
              & ~bus.flush_i & ~bus.hold_i;
        push      = SLOT_BUBBLE;
        push.we   = bus.wr_en_i;
        push.addr = bus.wr_addr_i;
        push.load = bus.is_load_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q <= '0;
        end else if (!bus.hold_i) begin
            sb_q[0] <= issue ? push : SLOT_BUBBLE;
            for (int k = 1; k < DEPTH; k++) begin
                sb_q[k] <= sb_q[k-1];
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (issue || bus.flush_i) begin
            cnt_d = '0;
        end else if (bus.hold_i) begin
            cnt_d = cnt_q;
        end else if (stall && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_q | (cnt_d == CNT_MAX);
        end
    end

    assign bus.opnd_o      = rst ? '0 : mux_opnd;
    assign bus.stall_o     = stall;
    assign bus.issue_o     = issue;
    assign bus.stall_cnt_o = cnt_q;
    assign bus.timeout_o   = to_q;

endmodule

// File: tb/tb_id_fwd_scoreboard.sv
// Directed bench for id_fwd_scoreboard: forwarding, load-use,
// flush, hold, watchdog and reset, on default and short-watchdog DUTs.
module tb_id_fwd_scoreboard;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;

    id_fwd_if #(.DATA_W(16), .REG_AW(4), .NUM_RD(2),
                .DEPTH(3), .CNT_W(4)) f ();
    id_fwd_if #(.DATA_W(16), .REG_AW(4), .NUM_RD(2),
                .DEPTH(3), .CNT_W(2)) g ();

    id_fwd_scoreboard #(
        .DATA_W(16), .REG_AW(4), .NUM_RD(2), .DEPTH(3),
        .LOAD_STAGE(2), .MAX_STALL(15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (f)
    );

    // Same stimulus, watchdog short enough for a 2-cycle load-use stall.
    id_fwd_scoreboard #(
        .DATA_W(16), .REG_AW(4), .NUM_RD(2), .DEPTH(3),
        .LOAD_STAGE(2), .MAX_STALL(2)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (g)
    );

    assign g.id_valid_i    = f.id_valid_i;
    assign g.rd_en_i       = f.rd_en_i;
    assign g.rd_addr_i     = f.rd_addr_i;
    assign g.rf_data_i     = f.rf_data_i;
    assign g.wr_en_i       = f.wr_en_i;
    assign g.wr_addr_i     = f.wr_addr_i;
    assign g.is_load_i     = f.is_load_i;
    assign g.stage_wdata_i = f.stage_wdata_i;
    assign g.flush_i       = f.flush_i;
    assign g.hold_i        = f.hold_i;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int v, input int we, input int wa,
                         input int ld, input int en,
                         input int a0, input int a1);
        f.id_valid_i = 1'(v);
        f.wr_en_i    = 1'(we);
        f.wr_addr_i  = 4'(wa);
        f.is_load_i  = 1'(ld);
        f.rd_en_i    = 2'(en);
        f.rd_addr_i  = {4'(a1), 4'(a0)};
        #1;
    endtask

    function automatic logic [31:0] op0();
        return 32'(f.opnd_o[15:0]);
    endfunction

    function automatic logic [31:0] op1();
        return 32'(f.opnd_o[31:16]);
    endfunction

    initial begin
        f.flush_i       = 1'b0;
        f.hold_i        = 1'b0;
        f.rf_data_i     = {16'hAAA1, 16'hAAA0};
        f.stage_wdata_i = {16'hBEEF, 16'h5555, 16'h1234};

        // Outputs forced quiet while in reset
        drive(1, 1, 3, 0, 3, 3, 3);
        chk("rst_stall", 32'(f.stall_o), 0);
        chk("rst_issue", 32'(f.issue_o), 0);
        chk("rst_opnd", f.opnd_o, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_cnt", 32'(f.stall_cnt_o), 0);
        chk("rst_to", 32'(f.timeout_o), 0);
        chk("rst_to2", 32'(g.timeout_o), 0);
        chk("empty_opnd", f.opnd_o, 32'hAAA1AAA0);
        chk("addu_issue", 32'(f.issue_o), 1);

        // ALU producer forwarded from EX then MEM without stalling
        tick();
        drive(1, 0, 0, 0, 1, 3, 3);
        chk("ex_fwd", op0(), 32'h1234);
        chk("ex_dis1", op1(), 32'hAAA1);
        chk("ex_stall", 32'(f.stall_o), 0);
        chk("ex_issue", 32'(f.issue_o), 1);
        tick();
        drive(1, 0, 0, 0, 2, 3, 3);
        chk("mem_fwd", op1(), 32'h5555);
        chk("mem_dis0", op0(), 32'hAAA0);

        // Load-use: two stall cycles, then WB forward
        tick();
        drive(1, 1, 2, 1, 0, 0, 0);
        chk("lw_issue", 32'(f.issue_o), 1);
        tick();
        drive(1, 0, 0, 0, 1, 2, 0);
        chk("lu_stall0", 32'(f.stall_o), 1);
        chk("lu_issue0", 32'(f.issue_o), 0);
        chk("lu_cnt0", 32'(f.stall_cnt_o), 0);
        tick();
        chk("lu_stall1", 32'(f.stall_o), 1);
        chk("lu_cnt1", 32'(f.stall_cnt_o), 1);
        tick();
        chk("lu_stall2", 32'(f.stall_o), 0);
        chk("lu_cnt2", 32'(f.stall_cnt_o), 2);
        chk("lu_issue2", 32'(f.issue_o), 1);
        chk("lu_wb_fwd", op0(), 32'hBEEF);
        chk("lu_to", 32'(f.timeout_o), 0);
        chk("lu_to2", 32'(g.timeout_o), 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("clr_cnt", 32'(f.stall_cnt_o), 0);
        chk("to2_sticky", 32'(g.timeout_o), 1);

        // Youngest of two writers to R5 wins
        tick();
        drive(1, 1, 5, 0, 0, 0, 0);
        tick();
        drive(1, 1, 5, 0, 0, 0, 0);
        tick();
        f.stage_wdata_i = {16'hBEEF, 16'h0002, 16'h0001};
        drive(0, 0, 0, 0, 3, 5, 5);
        chk("young_both", f.opnd_o, 32'h00010001);
        drive(0, 0, 0, 0, 2, 5, 5);
        chk("young_dis0", op0(), 32'hAAA0);
        chk("young_p1", op1(), 32'h0001);

        // R0 is an ordinary register
        tick();
        drive(1, 1, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("r0_fwd", op0(), 32'h0001);

        // Flush during load-use: no stall, no issue, no push
        tick();
        f.stage_wdata_i = {16'hBEEF, 16'h5555, 16'h1234};
        drive(1, 1, 6, 1, 0, 0, 0);
        tick();
        f.flush_i = 1'b1;
        drive(1, 1, 7, 0, 1, 6, 0);
        chk("fl_stall", 32'(f.stall_o), 0);
        chk("fl_issue", 32'(f.issue_o), 0);
        tick();
        f.flush_i = 1'b0;
        drive(1, 0, 0, 0, 3, 7, 6);
        chk("fl_bubble", op0(), 32'hAAA0);
        chk("fl_lw_mem", 32'(f.stall_o), 1);
        chk("fl_cnt", 32'(f.stall_cnt_o), 0);
        tick();
        chk("fl_stall_end", 32'(f.stall_o), 0);
        chk("fl_wb_fwd", op1(), 32'hBEEF);
        chk("fl_cnt1", 32'(f.stall_cnt_o), 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);

        // Hold freezes scoreboard and counter mid-stall
        tick();
        drive(1, 1, 4, 1, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 1, 4, 0);
        chk("hd_stall0", 32'(f.stall_o), 1);
        tick();
        f.hold_i = 1'b1;
        #1;
        chk("hd_stall", 32'(f.stall_o), 1);
        chk("hd_issue", 32'(f.issue_o), 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hd_loop_stall", 32'(f.stall_o), 1);
            chk("hd_loop_cnt", 32'(f.stall_cnt_o), 1);
            chk("hd_loop_to", 32'(f.timeout_o), 0);
        end
        f.hold_i = 1'b0;
        #1;
        chk("hd_rel_stall", 32'(f.stall_o), 1);
        chk("hd_rel_opnd", op0(), 32'h5555);
        tick();
        chk("hd_done_cnt", 32'(f.stall_cnt_o), 2);
        chk("hd_done_issue", 32'(f.issue_o), 1);
        chk("hd_done_opnd", op0(), 32'hBEEF);

        // Reset mid-stall wins and empties the scoreboard
        drive(1, 1, 1, 1, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 1, 1, 0);
        chk("rs_stall", 32'(f.stall_o), 1);
        chk("rs_to2_pre", 32'(g.timeout_o), 1);
        rst = 1'b1;
        #1;
        chk("rs_stall_rst", 32'(f.stall_o), 0);
        chk("rs_opnd_rst", f.opnd_o, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("rs_stall_after", 32'(f.stall_o), 0);
        chk("rs_issue_after", 32'(f.issue_o), 1);
        chk("rs_opnd_after", op0(), 32'hAAA0);
        chk("rs_cnt", 32'(f.stall_cnt_o), 0);
        chk("rs_to2", 32'(g.timeout_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_fwd_scoreboard.md
# id_fwd_scoreboard

Parametrised operand-resolution and hazard-interlock unit for the decode stage of the 16-bit mcpu pipeline. It tracks every in-flight register write in its own per-stage scoreboard and forwards results from any downstream stage. It stalls decode on load-use hazards, and bounds stall duration with a watchdog. It sits between the register file read ports and the ID/EX pipeline register, replacing ad-hoc EX/MEM forwarding inside decode.

## Interface
- DATA_W, 16, datapath width
- REG_AW, 4, register address width (general registers plus SP, T, IH)
- NUM_RD, 2, number of operand read ports
- DEPTH, 3, tracked stages after ID (slot 0 = EX, slot 1 = MEM, slot 2 = WB)
- LOAD_STAGE, 2, first slot index at which load data is valid; range 1..DEPTH-1
- MAX_STALL, 15, consecutive stall cycles before timeout; CNT_W = $clog2(MAX_STALL+1)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- id_valid_i  in  1  decoded instruction present in ID
- rd_en_i  in  NUM_RD  per-port read enable
- rd_addr_i  in  NUM_RD*REG_AW  per-port source register
- rf_data_i  in  NUM_RD*DATA_W  register-file read data
- wr_en_i  in  1  ID instruction writes a register
- wr_addr_i  in  REG_AW  ID instruction destination
- is_load_i  in  1  ID instruction is LW/LW_SP
- stage_wdata_i  in  DEPTH*DATA_W  result currently held in slot k
- flush_i  in  1  taken branch: discard the ID instruction
- hold_i  in  1  downstream freeze: scoreboard does not advance
- opnd_o  out  NUM_RD*DATA_W  resolved operands
- stall_o  out  1  ID must hold its instruction
- issue_o  out  1  ID instruction enters EX this cycle
- stall_cnt_o  out  CNT_W  consecutive stall cycles
- timeout_o  out  1  sticky watchdog flag

## Operation
- Scoreboard: DEPTH slots, each {we, addr, load}.
- The scoreboard advances on every clock edge with hold_i=0:
  - slot0 ← issue_o ? {wr_en_i, wr_addr_i, is_load_i} : bubble (we=0).
  - slot k ← slot k-1.
- hold_i=1: all slots keep their contents.
- Match on port p: rd_en_i[p] & slot.we & slot.addr==rd_addr_i[p]. The youngest match (lowest k) wins.
- Operand selection:
  - No match, or rd_en_i[p]=0: opnd_o[p] = rf_data_i[p].
  - Match in slot k: opnd_o[p] = stage_wdata_i[k].
- Hazard: the winning match is a load with k < LOAD_STAGE → stall_o=1. No register index is special; R0 is forwarded like any other register.
- issue_o = id_valid_i & ~stall_o & ~flush_i & ~hold_i.
- flush_i masks stall_o to 0, and a bubble enters slot0.
- stall_cnt_o:
  - Increments, saturating at MAX_STALL, each cycle stall_o=1 and hold_i=0.
  - Clears to 0 on issue_o or flush_i.
  - Holds while hold_i=1.
- timeout_o sets when stall_cnt_o reaches MAX_STALL and stays set until rst.

## Timing
- opnd_o, stall_o and issue_o are combinational from inputs and scoreboard state, with zero latency.
- Scoreboard, stall_cnt_o and timeout_o are registered and update on the edge.
- Load-use penalty is LOAD_STAGE cycles back-to-back. With defaults: 2 stall cycles, then the operand is forwarded from slot 2.
- Non-load producer in slot 0: forwarded the following cycle, with no stall.
- Reset: all slots bubble, stall_cnt_o=0, timeout_o=0.
- While rst=1: stall_o=0, issue_o=0, opnd_o=0.
- Reset asserted mid-stall wins on that edge. The instruction that follows reset sees an empty scoreboard.
- Simultaneous flush_i and load-use hazard: flush wins, with no stall and no push.
- Simultaneous hold_i and hazard: stall_o=1, but the counter does not advance.

## Structure
- Shared package mcpu_pkg holds:
  - DATA_W, REG_AW
  - SP_ADDR, T_ADDR, IH_ADDR constants
  - sb_slot_t struct {we, addr, load}
- One sub-module, fwd_mux: per-port priority selector, instantiated NUM_RD times via generate. It takes the slot array, stage data, rf data, rd_en and rd_addr, and returns the operand and a load-hazard bit.

## Test plan
- ADDU R3 issued, next instruction reads R3; stage_wdata_i[0]=0x1234 → opnd_o[0]=0x1234 with stall_o=0.
- LW R2 issued, next instruction reads R2 (defaults) → stall_o=1 for 2 cycles, stall_cnt_o goes 1, 2; third cycle opnd_o = stage_wdata_i[2]=0xBEEF and issue_o=1.
- Slot 0 and slot 1 both write R5 (0x0001, 0x0002) → opnd_o=0x0001, youngest wins.
- Load-use hazard with flush_i=1 the same cycle → stall_o=0, issue_o=0, slot 0 bubble next cycle.
- hold_i=1 for 20 cycles during a stall → scoreboard and stall_cnt_o frozen, timeout_o stays 0.
- Force MAX_STALL consecutive stalls → timeout_o=1 and stays set after the stall clears; rst clears it and empties the scoreboard.
